// File: rtl/ps2_scan_receiver.sv
// Purpose : PS/2 frame receiver that keeps only break (key-release) scan codes and queues them in a FWFT FIFO.
// Latency : 3 clk from the filtered stop-bit falling edge to key_code valid.
// Backpres: none toward the keyboard; a code arriving while the FIFO is full is dropped and overflow sticks.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   ps2c, ps2d   raw PS/2 clock/data from the connector
//   rd_key_code  pop strobe, one clk per code
//   key_code     FIFO head (8'h00 when empty)
//   kb_buf_empty FIFO empty flag
//   frame_err    one-cycle pulse on parity, stop or timeout error
//   overflow     sticky: a code was dropped on a full FIFO
module ps2_scan_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_ADDR_W = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rd_key_code,
  output logic [7:0] key_code,
  output logic       kb_buf_empty,
  output logic       frame_err,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam int CNT_W = FIFO_ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  // ---------------- input conditioning ----------------
  logic [1:0]            c_sync, d_sync;
  logic [FILTER_LEN-1:0] filt_reg, filt_next;
  logic                  f_clk, f_clk_q;
  logic                  fall_edge;

  // Newest synced sample enters at the MSB; the current sample is included
  // in the all-ones/all-zeros decision to avoid an extra cycle of delay.
  assign filt_next = {c_sync[1], filt_reg[FILTER_LEN-1:1]};
  assign fall_edge = f_clk_q & ~f_clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync   <= 2'b11;
      d_sync   <= 2'b11;
      filt_reg <= '1;
      f_clk    <= 1'b1;
      f_clk_q  <= 1'b1;
    end else begin
      c_sync   <= {c_sync[0], ps2c};
      d_sync   <= {d_sync[0], ps2d};
      filt_reg <= filt_next;
      f_clk_q  <= f_clk;
      if (&filt_next)       f_clk <= 1'b1;
      else if (~|filt_next) f_clk <= 1'b0;
    end
  end

  // ---------------- receive FSM ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_t;
  rx_state_t       rx_state;
  logic [3:0]      bit_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [9:0]      shreg;     // {stop, parity, data[7:0]} once full
  logic            rx_done;
  logic [7:0]      rx_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state  <= RX_IDLE;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      shreg     <= '0;
      rx_done   <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (fall_edge && !d_sync[1]) begin
            rx_state <= RX_SHIFT;
            bit_cnt  <= 4'd9;
            to_cnt   <= '0;
          end
        end
        RX_SHIFT: begin
          if (fall_edge) begin
            shreg  <= {d_sync[1], shreg[9:1]};
            to_cnt <= '0;
            if (bit_cnt == 4'd0) rx_state <= RX_CHECK;
            else                 bit_cnt  <= bit_cnt - 4'd1;
          end else if (to_cnt == TO_MAX) begin
            // keyboard stopped clocking mid-frame: abandon it
            rx_state  <= RX_IDLE;
            frame_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RX_CHECK: begin
          if ((^shreg[8:0]) && shreg[9]) begin
            rx_done <= 1'b1;
            rx_byte <= shreg[7:0];
          end else begin
            frame_err <= 1'b1;
          end
          rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- break filter FSM ----------------
  typedef enum logic {WAIT_BRK, GET_CODE} brk_state_t;
  brk_state_t brk_state;
  logic       push;

  // E0/F0 while waiting for the code are prefixes, never key codes.
  assign push = rx_done && (brk_state == GET_CODE) &&
                (rx_byte != EXT_CODE) && (rx_byte != BRK_CODE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk_state <= WAIT_BRK;
    end else if (rx_done) begin
      unique case (brk_state)
        WAIT_BRK: if (rx_byte == BRK_CODE) brk_state <= GET_CODE;
        GET_CODE: if (push)                brk_state <= WAIT_BRK;
        default:                           brk_state <= WAIT_BRK;
      endcase
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [7:0]             mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   empty, full, pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = rd_key_code && !empty;
  // a pop in the same cycle frees the slot the push needs
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  assign key_code     = empty ? 8'h00 : mem[rd_ptr];
  assign kb_buf_empty = empty;

endmodule
